key_switch_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the application UI block. It takes the raw DE10-Nano pushbuttons and slide switches, synchronises them into the `clock` domain, and debounces them. It then presents clean levels with unchanged polarity (KEY active-low), plus one-cycle press, release and switch-change pulses. The UI consumes `key_db`/`sw_db` in place of raw `KEY`/`SW`, so one physical press registers as one event.

---
 rtl/key_switch_conditioner_pkg.sv | 9 +
 rtl/key_switch_conditioner_if.sv | 24 ++
 rtl/key_switch_conditioner_debounce.sv | 58 +++++
 rtl/key_switch_conditioner.sv | 52 +++++
 tb/tb_key_switch_conditioner.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/key_switch_conditioner_pkg.sv
// Shared constants for the board input conditioning stage.
// Channel counts, default debounce interval and key idle level.
package silicon_shell_pkg;
  localparam int KEY_COUNT = 2;
  localparam int SW_COUNT  = 4;
  localparam int DEBOUNCE_50MHZ_20MS = 1_000_000;
  localparam logic KEY_RELEASED = 1'b1;
  localparam logic SW_OFF = 1'b0;
endpackage

// File: rtl/key_switch_conditioner_if.sv
// Raw and conditioned pushbutton/switch bundle.
// master drives raw levels, slave returns conditioned ones.
interface key_switch_conditioner_if;
  import silicon_shell_pkg::*;
  logic [KEY_COUNT-1:0] key_raw;
  logic [SW_COUNT-1:0]  sw_raw;
  logic [KEY_COUNT-1:0] key_db;
  logic [SW_COUNT-1:0]  sw_db;
  logic [KEY_COUNT-1:0] key_press;
  logic [KEY_COUNT-1:0] key_release;
  logic                 sw_changed;

  modport master (
    output key_raw, sw_raw,
    input  key_db, sw_db, key_press,
    input  key_release, sw_changed
  );

  modport slave (
    input  key_raw, sw_raw,
    output key_db, sw_db, key_press,
    output key_release, sw_changed
  );
endinterface

// File: rtl/key_switch_conditioner_debounce.sv
// One input channel: synchroniser, stability counter,
// debounced level and registered edge pulses.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 1_000_000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic          sync;
  logic          db_q, db_d;
  logic          prev_q;
  logic          rise_q, fall_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any return to agreement clears the count, so bounces restart it.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync != db_q) begin
      if (cnt_q == LAST) db_d = sync;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      db_q   <= RESET_LEVEL;
      prev_q <= RESET_LEVEL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      prev_q <= db_q;
      rise_q <= db_q & ~prev_q;
      fall_q <= ~db_q & prev_q;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/key_switch_conditioner.sv
// Debounces board keys and switches into clean levels
// plus press/release/change pulses for the UI block.
module key_switch_conditioner
  import silicon_shell_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
  parameter int SYNC_STAGES     = 2
) (
  input logic clock,
  input logic reset_n,
  key_switch_conditioner_if.slave bus
);
  logic [KEY_COUNT-1:0] key_db, key_rise, key_fall;
  logic [SW_COUNT-1:0]  sw_db, sw_rise, sw_fall;

  for (genvar i = 0; i < KEY_COUNT; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .RESET_LEVEL    (KEY_RELEASED)
    ) u_db (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (bus.key_raw[i]),
      .db     (key_db[i]),
      .rise   (key_rise[i]),
      .fall   (key_fall[i])
    );
  end

  for (genvar i = 0; i < SW_COUNT; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .RESET_LEVEL    (SW_OFF)
    ) u_db (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (bus.sw_raw[i]),
      .db     (sw_db[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  // Keys are active-low, so a falling level is a press.
  assign bus.key_db      = key_db;
  assign bus.key_press   = key_fall;
  assign bus.key_release = key_rise;
  assign bus.sw_db       = sw_db;
  assign bus.sw_changed  = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_key_switch_conditioner.sv
// Scoreboard bench for key_switch_conditioner
// with an 8-cycle debounce and 2-stage synchroniser.
module tb_key_switch_conditioner;
  import silicon_shell_pkg::*;

  typedef struct {
    int         cyc;
    logic [4:0] pulse;
    logic [5:0] lvl;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;
  ev_t  sb[$];
  logic [5:0] lvl_m;
  logic [4:0] obs;
  ev_t  ev;

  key_switch_conditioner_if bus();

  key_switch_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive new raw levels, predict the pulses and check db timing.
  task automatic apply(
    input logic [1:0] k,
    input logic [3:0] s,
    input string      tag
  );
    int n;
    logic [5:0] nw;
    logic [4:0] p;
    ev_t e;
    @(negedge clk);
    n  = cyc;
    nw = {k, s};
    p  = {~k & lvl_m[5:4], k & ~lvl_m[5:4], |(s ^ lvl_m[3:0])};
    bus.key_raw = k;
    bus.sw_raw  = s;
    e.cyc   = n + 11;
    e.pulse = p;
    e.lvl   = nw;
    sb.push_back(e);
    wait_to(n + 9);
    chk({tag, "_hold"}, {bus.key_db, bus.sw_db}, lvl_m);
    wait_to(n + 10);
    chk({tag, "_db"}, {bus.key_db, bus.sw_db}, nw);
    lvl_m = nw;
    wait_to(n + 14);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      obs = {bus.key_press, bus.key_release, bus.sw_changed};
      if (obs != 5'b0) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", {27'b0, obs}, 32'h0);
        end else begin
          ev = sb.pop_front();
          chk("pulse_cyc", cyc, ev.cyc);
          chk("pulse_val", {27'b0, obs}, {27'b0, ev.pulse});
          chk("pulse_lvl", {bus.key_db, bus.sw_db}, ev.lvl);
        end
      end
    end
  end

  initial begin
    int n;
    int r;
    ev_t e;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.key_raw = 2'b11;
    bus.sw_raw  = 4'b0000;
    lvl_m = 6'b11_0000;

    repeat (3) @(negedge clk);
    chk("rst_key_db", bus.key_db, 2'b11);
    chk("rst_sw_db", bus.sw_db, 4'b0000);
    chk("rst_pulses",
        {bus.key_press, bus.key_release, bus.sw_changed}, 5'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_lvl", {bus.key_db, bus.sw_db}, 6'b11_0000);

    apply(2'b10, 4'b0000, "press0");
    apply(2'b11, 4'b0000, "release0");

    // Short low on key1 must be swallowed.
    @(negedge clk);
    n = cyc;
    bus.key_raw[1] = 1'b0;
    repeat (5) @(negedge clk);
    bus.key_raw[1] = 1'b1;
    wait_to(n + 20);
    chk("bounce_hold", bus.key_db, 2'b11);
    apply(2'b01, 4'b0000, "press1");
    apply(2'b11, 4'b0000, "release1");

    apply(2'b11, 4'b1011, "sw_bundle");

    apply(2'b00, 4'b1011, "both_press");
    repeat (7) @(negedge clk);
    apply(2'b11, 4'b1011, "both_release");

    // Reset five counts into a key0 press.
    @(negedge clk);
    n = cyc;
    bus.key_raw[0] = 1'b0;
    wait_to(n + 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_key_db", bus.key_db, 2'b11);
    chk("midrst_sw_db", bus.sw_db, 4'b0000);
    lvl_m = 6'b11_0000;
    repeat (2) @(negedge clk);
    r = cyc;
    rst_n = 1'b1;
    e.cyc   = r + 11;
    e.pulse = 5'b01_00_1;
    e.lvl   = 6'b10_1011;
    sb.push_back(e);
    wait_to(r + 9);
    chk("postrst_hold", {bus.key_db, bus.sw_db}, 6'b11_0000);
    wait_to(r + 10);
    chk("postrst_db", {bus.key_db, bus.sw_db}, 6'b10_1011);
    lvl_m = 6'b10_1011;
    wait_to(r + 14);

    apply(2'b11, 4'b1011, "final_release");
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
